// File: rtl/sq_add_stage_pkg.sv
// Shared definitions for the square-plus-root stage: FSM encoding and default widths.
// A_W_DEF/R_W_DEF match the upstream 8-bit cube-root unit.
package sq_add_stage_pkg;

  localparam int A_W_DEF = 8;
  localparam int R_W_DEF = 4;
  localparam int Y_W_DEF = 2 * A_W_DEF + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2
  } state_e;

endpackage

// File: rtl/sq_add_stage_mul_shift_add.sv
// Sequential shift-add squarer: one partial product of a*a per step, A_W steps.
// load_i captures the operand and clears the accumulator; done_o flags the last step.
module sq_add_stage_mul_shift_add #(
  parameter int A_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [A_W-1:0]     a_i,
  output logic               done_o,
  output logic [2*A_W-1:0]   prod_o
);

  localparam int P_W   = 2 * A_W;
  localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

  logic [A_W-1:0]   a_q,   a_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      a_d   = a_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      if (a_q[cnt_q]) begin
        acc_d = acc_q + (P_W'(a_q) << cnt_q);
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = step_i && (cnt_q == CNT_W'(A_W - 1));
  assign prod_o = acc_q;

endmodule

// File: rtl/sq_add_stage.sv
// Computes y = a*a + root using a shift-add squarer followed by one add cycle.
// Same start/busy handshake as the cube-root unit so a controller can chain the two.
module sq_add_stage
  import sq_add_stage_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int R_W = R_W_DEF,
  parameter int Y_W = 2 * A_W + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [A_W-1:0] a_bi,
  input  logic [R_W-1:0] root_bi,
  output logic           busy_o,
  output logic [Y_W-1:0] y_bo
);

  state_e           state_q, state_d;
  logic             busy_q,  busy_d;
  logic [Y_W-1:0]   y_q,     y_d;
  logic [R_W-1:0]   r_q,     r_d;

  logic             mul_load;
  logic             mul_step;
  logic             mul_done;
  logic [2*A_W-1:0] mul_prod;

  sq_add_stage_mul_shift_add #(
    .A_W (A_W)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (mul_load),
    .step_i (mul_step),
    .a_i    (a_bi),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    y_d      = y_q;
    r_d      = r_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mul_load = 1'b1;
          r_d      = root_bi;
          busy_d   = 1'b1;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_done) state_d = S_ADD;
      end
      S_ADD: begin
        // y only changes here, so the previous result stays visible while busy.
        y_d     = Y_W'(mul_prod) + Y_W'(r_q);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      y_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  assign busy_o = busy_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_sq_add_stage.sv
// Self-checking bench for sq_add_stage: queued expectations from an arithmetic model,
// a negedge monitor that checks results, busy length and result hold.
module tb_sq_add_stage;

  localparam int A_W = 8;
  localparam int R_W = 4;
  localparam int Y_W = 2 * A_W + 1;
  localparam int BUSY_CYCLES = A_W + 1;
  localparam int WAIT_LIMIT  = 200;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [A_W-1:0] a_bi;
  logic [R_W-1:0] root_bi;
  logic           busy_o;
  logic [Y_W-1:0] y_bo;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned exp_q[$];

  int unsigned last_y   = 0;
  int          busy_cnt = 0;
  logic        prev_busy = 1'b0;

  sq_add_stage #(
    .A_W (A_W),
    .R_W (R_W),
    .Y_W (Y_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .root_bi (root_bi),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int unsigned actual, input int unsigned expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int unsigned cube_root(input int unsigned n);
    int unsigned k = 0;
    while ((k + 1) * (k + 1) * (k + 1) <= n) k++;
    return k;
  endfunction

  // Monitor: counts busy cycles, checks hold of the previous result, checks completions.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
      last_y    = 0;
    end else begin
      if (busy_o) begin
        busy_cnt++;
        check("y_hold_while_busy", int'(y_bo), last_y);
      end
      if (prev_busy && !busy_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          check("y_result", int'(y_bo), exp_q.pop_front());
        end
        check("busy_cycles", busy_cnt, BUSY_CYCLES);
        last_y   = int'(y_bo);
        busy_cnt = 0;
      end
      prev_busy = busy_o;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < WAIT_LIMIT) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= WAIT_LIMIT) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic start_op(input int unsigned a, input int unsigned r);
    wait_idle();
    a_bi    = A_W'(a);
    root_bi = R_W'(r);
    start_i = 1'b1;
    exp_q.push_back(a * a + r);
    @(negedge clk_i);
    start_i = 1'b0;
    a_bi    = A_W'($urandom);
    root_bi = R_W'($urandom);
  endtask

  task automatic drain();
    @(negedge clk_i);
    wait_idle();
    @(negedge clk_i);
  endtask

  initial begin
    int unsigned ra, rr, gap;
    rst_i   = 1'b0;
    start_i = 1'b0;
    a_bi    = '0;
    root_bi = '0;
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_y", int'(y_bo), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    start_op(0, 0);
    drain();
    start_op(3, 2);
    drain();

    // Back-to-back: second start lands in the first IDLE cycle after completion.
    start_op(255, 6);
    start_op(16, 5);
    drain();

    // Start pulses and operand changes mid-operation must be ignored.
    start_op(10, 2);
    repeat (3) @(negedge clk_i);
    start_i = 1'b1;
    a_bi    = 8'd200;
    root_bi = 4'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    a_bi    = 8'd77;
    root_bi = 4'd9;
    drain();

    // Asynchronous reset mid-operation, off the clock edge.
    start_op(100, 4);
    repeat (3) @(negedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    check("async_reset_busy", busy_o, 0);
    check("async_reset_y", int'(y_bo), 0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_busy", busy_o, 0);
    start_op(7, 1);
    drain();

    // Chained with the cube-root unit: its output for 125 feeds root_bi.
    start_op(12, cube_root(125));
    drain();

    for (int i = 0; i < 25; i++) begin
      ra  = $urandom_range(0, 255);
      rr  = $urandom_range(0, 15);
      gap = $urandom_range(0, 3);
      start_op(ra, rr);
      if (gap != 0) begin
        wait_idle();
        repeat (gap) @(negedge clk_i);
      end
    end
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sq_add_stage.md
Name: sq_add_stage

Overview:
- Downstream consumer of the 8-bit cube-root unit.
- Captures the 4-bit root from the root unit together with an 8-bit operand a, then computes y = a*a + root.
- Uses a sequential shift-add multiplier (one partial product per clock), then a final add.
- Uses the same start/busy handshake as the root unit, so the top-level controller chains them: root unit busy falls → pulse start_i here.

Parameters:
- A_W, 8, operand a width
- R_W, 4, root input width (matches root unit output)
- Y_W, 2*A_W+1 (17), result width: square plus root carry headroom

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  start request; sampled only in IDLE
- a_bi  in  A_W  operand to be squared; sampled with start_i
- root_bi  in  R_W  cube-root result from root unit; sampled with start_i
- busy_o  out  1  high while an operation is in progress
- y_bo  out  Y_W  result; valid whenever busy_o is low after the first completion

Behaviour:
- Reset (rst_i low, asynchronous, any state):
  - state=IDLE, busy_o=0, y_bo=0.
  - Internal accumulator, counter, a_reg and r_reg cleared.
  - Takes effect immediately and aborts any operation in progress. No partial result reaches y_bo.
- States: IDLE, MUL, ADD (2-bit encoding).
- IDLE: on a rising edge with start_i=1:
  - a_reg<=a_bi, r_reg<=root_bi, acc<=0, cnt<=0.
  - state<=MUL, busy_o<=1.
  - With start_i=0, state and outputs hold.
- MUL: each edge:
  - If a_reg[cnt]=1, acc <= acc + (a_reg << cnt), zero-extended to Y_W.
  - cnt<=cnt+1.
  - The edge processing cnt=A_W-1 moves state<=ADD.
  - Exactly A_W MUL cycles; cnt is 3 bits and never wraps inside an operation.
- ADD: one edge:
  - y_bo <= acc + zero-extend(r_reg), busy_o<=0, state<=IDLE.
- Latency: start sampled at edge E0; busy_o high after E0 through E9; y_bo updated and busy_o low at E9. That is 9 busy cycles per operation (A_W+1 in general).
- start_i while busy (MUL/ADD): ignored. Operands are not re-sampled and the operation is not restarted.
- start_i high in the first IDLE cycle after completion: accepted normally, so back-to-back throughput is one operation per 10 cycles.
- y_bo holds its previous result during a new operation and changes only at the ADD edge.
- Inputs a_bi/root_bi may change freely after the start edge; only the registered copies are used.
- Width: the maximum result 255*255+15 = 65040 fits in 16 bits. Y_W=17 is kept for generic A_W/R_W. No overflow or saturation logic.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (S_IDLE=0, S_MUL=1, S_ADD=2), default A_W/R_W, and derived Y_W.
- One sub-module is natural: mul_shift_add.
  - Holds the multiplicand/multiplier registers, accumulator, and counter.
  - Interface: start, done, 2*A_W product.
- sq_add_stage keeps the FSM, operand capture, final adder, and handshake.

Test Plan:
- Reset then a=0, root=0, pulse start → busy_o high for 9 cycles, then y_bo=0, busy_o=0.
- a=3, root=2 → y_bo=11 at completion; busy_o falls on the same edge y_bo updates (count exactly 9 busy cycles).
- a=255, root=6 (root unit output for 255) → y_bo=65031; then a=16, root=5 back-to-back (start in first IDLE cycle) → y_bo=261, and 65031 is held during the second operation.
- a=10, root=2 started; mid-operation pulse start with a=200, root=5 and change a_bi/root_bi → ignored, result y_bo=102.
- a=100, root=4 started; assert rst_i low asynchronously (off clock edge) at cycle 4 → busy_o=0 and y_bo=0 immediately. After release, a=7, root=1 → y_bo=50.
- Chained with root unit: root unit in=125; on its busy fall pulse start with a=12 → y_bo=149.
